// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  typedef logic [2:0] fetch_state_t;

  localparam fetch_state_t ST_IDLE = 3'd0;
  localparam fetch_state_t ST_REQ  = 3'd1;
  localparam fetch_state_t ST_WAIT = 3'd2;
  localparam fetch_state_t ST_DROP = 3'd3;
  localparam fetch_state_t ST_HALT = 3'd4;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [31:0] RESET_VECTOR = 32'h8000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        err;
  } fetch_entry_t;

endpackage

// File: rtl/m_fetch_out_reg.sv
// Fetch-to-decode holding register: a head entry driving if_* plus one skid entry that
// absorbs the single response that can land while decode is stalled.
module m_fetch_out_reg
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         load,
  input  fetch_entry_t load_entry,
  input  logic         ready,
  output logic         valid,
  output fetch_entry_t entry,
  output logic         can_issue
);

  fetch_entry_t head_q, head_d, skid_q, skid_d;
  logic         head_vld_q, head_vld_d, skid_vld_q, skid_vld_d;
  logic         head_free;

  assign head_free = !head_vld_q || ready;

  always_comb begin
    head_d     = head_q;
    skid_d     = skid_q;
    head_vld_d = head_vld_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      head_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (head_free) begin
      if (skid_vld_q) begin
        head_d     = skid_q;
        head_vld_d = 1'b1;
        skid_vld_d = load;
        if (load) begin
          skid_d = load_entry;
        end
      end else begin
        head_vld_d = load;
        if (load) begin
          head_d = load_entry;
        end
      end
    end else if (load) begin
      skid_d     = load_entry;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= '{pc: 32'h0, instr: NOP_INSTR, err: 1'b0};
      skid_q     <= '0;
      head_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      skid_q     <= skid_d;
      head_vld_q <= head_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  assign valid = head_vld_q;
  assign entry = head_q;
  // A new request may only start when its response is guaranteed a free entry.
  assign can_issue = !skid_vld_q && head_free;

endmodule

// File: rtl/m_instr_fetch.sv
// Instruction fetch: owns pc_ff, issues one outstanding imem request, feeds decode.
// Optional misaligned-redirect fault reporting is enabled by FETCH_MISALIGN_CHK_EN.
module m_instr_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned       XLEN     = 32,
  parameter logic [XLEN-1:0]   RESET_PC = RESET_VECTOR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            fetch_stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr,
  output logic            if_err,
  input  logic            if_ready,
  output logic [XLEN-1:0] pc_ff,
  output logic [XLEN-1:0] pc_plus_4
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            load;
  fetch_entry_t    load_entry;
  fetch_entry_t    head;
  logic            can_issue;
  logic            can_go;
  logic            misaligned;
  logic            redir_misaligned;

`ifdef FETCH_MISALIGN_CHK_EN
  assign imem_addr        = pc_q;
  assign misaligned       = pc_q[1:0] != 2'b00;
  assign redir_misaligned = redirect_pc[1:0] != 2'b00;
`else
  assign imem_addr        = {pc_q[XLEN-1:2], 2'b00};
  assign misaligned       = 1'b0;
  assign redir_misaligned = 1'b0;
`endif

  assign pc_ff     = pc_q;
  assign pc_plus_4 = pc_q + XLEN'(4);
  assign imem_req  = state_q == ST_REQ;
  assign can_go    = !fetch_stall && can_issue && !redirect_valid;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    load       = 1'b0;
    load_entry = '{pc: pc_q, instr: imem_rsp_data, err: imem_rsp_err};
    case (state_q)
      ST_IDLE: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
        end else if (misaligned) begin
          if (can_issue) begin
            load             = 1'b1;
            load_entry.instr = NOP_INSTR;
            load_entry.err   = 1'b1;
            state_d          = ST_HALT;
          end
        end else if (can_go) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (imem_gnt) begin
          if (redirect_valid) begin
            pc_d    = redirect_pc;
            state_d = ST_DROP;
          end else begin
            state_d = ST_WAIT;
          end
        end else if (redirect_valid) begin
          // Ungranted: retarget in place; a misaligned target must not reach the bus.
          pc_d = redirect_pc;
          if (redir_misaligned) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_WAIT: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = imem_rsp_valid ? ST_IDLE : ST_DROP;
        end else if (imem_rsp_valid) begin
          load = 1'b1;
          if (imem_rsp_err) begin
            state_d = ST_HALT;
          end else begin
            pc_d    = pc_plus_4;
            state_d = can_go ? ST_REQ : ST_IDLE;
          end
        end
      end
      ST_DROP: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
        end
        if (imem_rsp_valid) begin
          state_d = ST_IDLE;
        end
      end
      ST_HALT: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  m_fetch_out_reg u_out_reg (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .load       (load),
    .load_entry (load_entry),
    .ready      (if_ready),
    .valid      (if_valid),
    .entry      (head),
    .can_issue  (can_issue)
  );

  assign if_pc    = head.pc;
  assign if_instr = head.instr;
  assign if_err   = head.err;

endmodule
